// File: rtl/spcpu_mem_responder.sv
// Byte-addressed big-endian memory responder for the spcpu data bus, with reset-time clear sweep.
// Optional write protection of [ROM_BASE, ROM_LAST] is enabled by defining SPCPU_MEM_RESP_WR_PROTECT_EN.
module spcpu_mem_responder #(
   parameter int          ADDR_W         = 16,
   parameter string       INIT_FILE      = "",
   parameter bit          CLEAR_ON_RESET = 1'b1,
   parameter logic [31:0] ROM_BASE       = 32'h0000_8000,
   parameter logic [31:0] ROM_LAST       = 32'h0000_80FF
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [ADDR_W-1:0] addr_in,
   input  logic              data_acc_sz,
   input  logic              write_data_we,
   input  logic [15:0]       write_data_in,
   output logic [15:0]       read_data_out,
   output logic              busy,
   output logic              wp_violation
);

   localparam int IW    = ADDR_W - 1;
   localparam int DEPTH = 2 ** IW;

   typedef enum logic {ST_CLEAR, ST_SERVE} state_t;

   state_t            state_q, state_d;
   logic [IW-1:0]     cnt_q, cnt_d;
   logic [15:0]       rd_q, rd_d;
   logic              wp_q, wp_d;

   // Each word holds the even byte in [1] and the odd byte in [0].
   logic [1:0][7:0]   mem [DEPTH];

   logic [IW-1:0]     idx, idx_nxt, ev_idx, od_idx;
   logic [ADDR_W-1:0] a1;
   logic [7:0]        b0, b1, ev_wd, od_wd, hi_wd;
   logic              ev_we, od_we, we_b0, we_b1;
   logic              prot_a0, prot_a1, prot_ce, prot_co;

`ifdef SPCPU_MEM_RESP_WR_PROTECT_EN
   function automatic logic in_rom(input logic [ADDR_W-1:0] a);
      logic [31:0] ax;
      ax = 32'(a);
      return (ax >= ROM_BASE) && (ax <= ROM_LAST);
   endfunction

   assign prot_a0 = in_rom(addr_in);
   assign prot_a1 = in_rom(a1);
   assign prot_ce = in_rom({cnt_q, 1'b0});
   assign prot_co = in_rom({cnt_q, 1'b1});
`else
   logic unused_rom;
   assign unused_rom = ^{ROM_BASE, ROM_LAST};
   assign prot_a0    = 1'b0;
   assign prot_a1    = 1'b0;
   assign prot_ce    = 1'b0;
   assign prot_co    = 1'b0;
`endif

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      rd_d    = rd_q;
      wp_d    = wp_q;
      idx     = addr_in[ADDR_W-1:1];
      idx_nxt = idx + 1'b1;
      a1      = addr_in + 1'b1;
      ev_idx  = addr_in[0] ? idx_nxt : idx;
      od_idx  = idx;
      ev_we   = 1'b0;
      od_we   = 1'b0;
      ev_wd   = 8'h00;
      od_wd   = 8'h00;
      we_b0   = 1'b0;
      we_b1   = 1'b0;
      hi_wd   = data_acc_sz ? write_data_in[15:8] : write_data_in[7:0];
      // An odd address starts in the odd bank and spills into the next even word.
      b0      = addr_in[0] ? mem[idx][0]     : mem[idx][1];
      b1      = addr_in[0] ? mem[idx_nxt][1] : mem[idx][0];

      case (state_q)
         ST_CLEAR: begin
            ev_idx = cnt_q;
            od_idx = cnt_q;
            ev_we  = !prot_ce;
            od_we  = !prot_co;
            rd_d   = 16'h0000;
            cnt_d  = cnt_q + 1'b1;
            if (&cnt_q) state_d = ST_SERVE;
         end
         default: begin
            if (write_data_we) begin
               we_b0 = !prot_a0;
               we_b1 = data_acc_sz && !prot_a1;
               wp_d  = wp_q | prot_a0 | (data_acc_sz & prot_a1);
               if (!addr_in[0]) begin
                  ev_we = we_b0;  ev_wd = hi_wd;
                  od_we = we_b1;  od_wd = write_data_in[7:0];
               end else begin
                  od_we = we_b0;  od_wd = hi_wd;
                  ev_we = we_b1;  ev_wd = write_data_in[7:0];
               end
            end else begin
               rd_d = data_acc_sz ? {b0, b1} : {8'h00, b0};
            end
         end
      endcase

      if (reset) begin
         state_d = CLEAR_ON_RESET ? ST_CLEAR : ST_SERVE;
         cnt_d   = '0;
         rd_d    = 16'h0000;
         wp_d    = 1'b0;
         ev_we   = 1'b0;
         od_we   = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rd_q    <= rd_d;
      wp_q    <= wp_d;
      if (ev_we) mem[ev_idx][1] <= ev_wd;
      if (od_we) mem[od_idx][0] <= od_wd;
   end

   assign read_data_out = rd_q;
   assign busy          = (state_q == ST_CLEAR);
   assign wp_violation  = wp_q;

endmodule

// File: tb/tb_spcpu_mem_responder.sv
// Bench for spcpu_mem_responder: sweep timing on a small instance, directed vectors and
// randomized traffic against a byte-array reference model on a full-size instance.
module tb_spcpu_mem_responder;

`ifdef SPCPU_MEM_RESP_WR_PROTECT_EN
   localparam bit PROT_ON = 1'b1;
`else
   localparam bit PROT_ON = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst_b, rst_s, sz, we;
   logic [15:0] addr, wd;
   logic [15:0] rd_b, rd_s;
   logic        busy_b, busy_s, wp_b, wp_s;

   always #5 clk = ~clk;

   spcpu_mem_responder #(.ADDR_W(16)) u_big (
      .clk(clk), .reset(rst_b), .addr_in(addr), .data_acc_sz(sz), .write_data_we(we),
      .write_data_in(wd), .read_data_out(rd_b), .busy(busy_b), .wp_violation(wp_b));

   spcpu_mem_responder #(.ADDR_W(6)) u_small (
      .clk(clk), .reset(rst_s), .addr_in(addr[5:0]), .data_acc_sz(sz), .write_data_we(we),
      .write_data_in(wd), .read_data_out(rd_s), .busy(busy_s), .wp_violation(wp_s));

   int errs = 0;
   int checks = 0;

   task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
      checks++;
      if (act !== exp) begin
         errs++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Reference model: flat byte array with big-endian 8/16-bit access rules.
   logic [7:0]  mm [65536];
   logic [15:0] m_rd;
   logic        m_wp;

   function automatic bit m_prot(input logic [15:0] a);
      return PROT_ON && (a >= 16'h8000) && (a <= 16'h80FF);
   endfunction

   task automatic m_apply(input bit w, input bit s, input logic [15:0] a, input logic [15:0] d);
      logic [15:0] a_n;
      a_n = a + 16'd1;
      if (w) begin
         if (m_prot(a)) m_wp = 1'b1;
         else mm[a] = s ? d[15:8] : d[7:0];
         if (s) begin
            if (m_prot(a_n)) m_wp = 1'b1;
            else mm[a_n] = d[7:0];
         end
      end else begin
         m_rd = s ? {mm[a], mm[a_n]} : {8'h00, mm[a]};
      end
   endtask

   // Called at a negedge; returns at the next negedge with the result visible.
   task automatic op(input bit w, input bit s, input logic [15:0] a, input logic [15:0] d);
      we = w; sz = s; addr = a; wd = d;
      @(negedge clk);
      we = 1'b0; sz = 1'b0; addr = 16'h0000; wd = 16'h0000;
   endtask

   task automatic count_busy_small(input string name);
      int n;
      n = 0;
      while (busy_s && n < 100) begin
         n++;
         @(negedge clk);
      end
      chk(name, 16'(n), 16'd32);
   endtask

   typedef struct {
      bit          w;
      bit          s;
      logic [15:0] a;
      logic [15:0] d;
      logic [15:0] exp;
   } vec_t;

   vec_t tbl [16];

   initial begin
      int n;
      for (int i = 0; i < 65536; i++) mm[i] = 8'h00;
      m_rd = 16'h0000;
      m_wp = 1'b0;

      tbl[0]  = '{1'b1, 1'b1, 16'h0040, 16'hBEEF, 16'h0000};
      tbl[1]  = '{1'b0, 1'b1, 16'h0040, 16'h0000, 16'hBEEF};
      tbl[2]  = '{1'b0, 1'b0, 16'h0041, 16'h0000, 16'h00EF};
      tbl[3]  = '{1'b1, 1'b1, 16'hFFFF, 16'h1234, 16'h00EF};
      tbl[4]  = '{1'b0, 1'b0, 16'hFFFF, 16'h0000, 16'h0012};
      tbl[5]  = '{1'b0, 1'b0, 16'h0000, 16'h0000, 16'h0034};
      tbl[6]  = '{1'b0, 1'b1, 16'hFFFF, 16'h0000, 16'h1234};
      tbl[7]  = '{1'b1, 1'b1, 16'h0010, 16'hAABB, 16'h1234};
      tbl[8]  = '{1'b1, 1'b0, 16'h0011, 16'h00CC, 16'h1234};
      tbl[9]  = '{1'b0, 1'b1, 16'h0010, 16'h0000, 16'hAACC};
      tbl[10] = '{1'b0, 1'b0, 16'h0010, 16'h0000, 16'h00AA};
      tbl[11] = '{1'b1, 1'b1, 16'h7FFF, 16'h5566, 16'h00AA};
      tbl[12] = '{1'b0, 1'b0, 16'h7FFF, 16'h0000, 16'h0055};
      tbl[13] = '{1'b0, 1'b0, 16'h8000, 16'h0000, PROT_ON ? 16'h0000 : 16'h0066};
      tbl[14] = '{1'b0, 1'b1, 16'h7FFE, 16'h0000, 16'h0055};
      tbl[15] = '{1'b0, 1'b1, 16'h7FFF, 16'h0000, PROT_ON ? 16'h5500 : 16'h5566};

      rst_b = 1'b1; rst_s = 1'b1;
      we = 1'b0; sz = 1'b0; addr = 16'h0000; wd = 16'h0000;
      @(negedge clk);
      rst_b = 1'b0; rst_s = 1'b0;
      chk("reset_busy_big", 16'(busy_b), 16'd1);
      chk("reset_rd_big", rd_b, 16'h0000);
      chk("reset_wp_big", 16'(wp_b), 16'd0);
      chk("reset_rd_small", rd_s, 16'h0000);

      count_busy_small("sweep_len");
      op(1'b0, 1'b1, 16'h0010, 16'h0000);
      chk("post_sweep_read", rd_s, 16'h0000);

      // Restart the small sweep, then hit it with reset again partway through.
      rst_s = 1'b1;
      @(negedge clk);
      rst_s = 1'b0;
      repeat (10) @(negedge clk);
      chk("mid_sweep_busy", 16'(busy_s), 16'd1);
      rst_s = 1'b1;
      @(negedge clk);
      rst_s = 1'b0;
      count_busy_small("restart_sweep_len");

      n = 0;
      while (busy_b && n < 40000) begin
         n++;
         @(negedge clk);
      end
      chk("big_sweep_done", 16'(busy_b), 16'd0);

      for (int i = 0; i < 16; i++) begin
         op(tbl[i].w, tbl[i].s, tbl[i].a, tbl[i].d);
         m_apply(tbl[i].w, tbl[i].s, tbl[i].a, tbl[i].d);
         chk($sformatf("vec%0d", i), rd_b, tbl[i].exp);
      end
      chk("wp_after_vectors", 16'(wp_b), 16'(PROT_ON));

      for (int i = 0; i < 1500; i++) begin
         bit          w, s;
         logic [15:0] a, d, base;
         case ($urandom_range(0, 2))
            0:       base = 16'h0000;
            1:       base = 16'h7FF0;
            default: base = 16'hFFF0;
         endcase
         a = base + 16'($urandom_range(0, 31));
         w = 1'($urandom_range(0, 1));
         s = 1'($urandom_range(0, 1));
         d = 16'($urandom);
         op(w, s, a, d);
         m_apply(w, s, a, d);
         chk($sformatf("rand%0d_rd", i), rd_b, m_rd);
         chk($sformatf("rand%0d_wp", i), 16'(wp_b), 16'(m_wp));
      end

      chk("small_wp", 16'(wp_s), 16'd0);

      rst_b = 1'b1;
      @(negedge clk);
      rst_b = 1'b0;
      chk("rereset_rd", rd_b, 16'h0000);
      chk("rereset_wp", 16'(wp_b), 16'd0);
      chk("rereset_busy", 16'(busy_b), 16'd1);

      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end

endmodule
